// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: FSM encoding and default sizes.
// The optional forwarding path is enabled with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NRD    = 2;

endpackage : regfile_pkg

// File: rtl/regfile_rdport.sv
// One combinational read port: index select, zero-register mask, CLEAR mask.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to a matching read index.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ZERO_REG = 1
) (
    input  logic [2**ADDR_W-1:0][DATA_W-1:0] i_mem,
    input  logic                             i_run,
    input  logic                             i_wr_en,
    input  logic [ADDR_W-1:0]                i_wa,
    input  logic [DATA_W-1:0]                i_wd,
    input  logic [ADDR_W-1:0]                i_ra,
    output logic [DATA_W-1:0]                o_rd
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic w_fwd;
    logic w_zero_ra;

    // i_wr_en is already qualified with RUN and the zero-register discard
    assign w_fwd     = BYPASS && i_wr_en && (i_wa == i_ra);
    assign w_zero_ra = (ZERO_REG != 0) && (i_ra == '0);

    always_comb begin
        o_rd = i_mem[i_ra];
        if (!i_run) begin
            o_rd = '0;
        end else if (w_zero_ra) begin
            o_rd = '0;
        end else if (w_fwd) begin
            o_rd = i_wd;
        end
    end

endmodule : regfile_rdport

// File: rtl/regfile_mp.sv
// Multi-port register file with a self-clearing start-up sequence and NRD read ports.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NRD      = DEF_NRD,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic [NRD*ADDR_W-1:0]    ra,
    output logic [NRD*DATA_W-1:0]    rd,
    output logic                     ready,
    output logic                     wr_drop
);

    localparam int                DEPTH    = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [ADDR_W-1:0]             r_clr_idx;
    logic [ADDR_W-1:0]             w_clr_idx_nxt;
    logic                          r_ready;
    logic                          r_wr_drop;
    logic [DEPTH-1:0][DATA_W-1:0]  r_mem;

    logic w_run;
    logic w_zero_wa;
    logic w_wr_en;
    logic w_wr_drop_nxt;

    assign w_run         = (r_state == RUN);
    assign w_zero_wa     = (ZERO_REG != 0) && (wa == '0);
    assign w_wr_en       = w_run && we && !w_zero_wa;
    // Any requested write that does not land (CLEAR, or index 0) is flagged
    assign w_wr_drop_nxt = we && !w_wr_en;

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            CLEAR: begin
                w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
                if (r_clr_idx == LAST_IDX) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
            r_ready   <= 1'b0;
            r_wr_drop <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_ready   <= (w_state_nxt == RUN);
            r_wr_drop <= w_wr_drop_nxt;
        end
    end

    // Storage is deliberately not reset; zeroing happens only via the CLEAR walk
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_wr_en) begin
            r_mem[wa] <= wd;
        end
    end

    generate
        for (genvar p = 0; p < NRD; p++) begin : g_rdport
            regfile_rdport #(
                .ADDR_W   (ADDR_W),
                .DATA_W   (DATA_W),
                .ZERO_REG (ZERO_REG)
            ) u_rdport (
                .i_mem   (r_mem),
                .i_run   (w_run),
                .i_wr_en (w_wr_en),
                .i_wa    (wa),
                .i_wd    (wd),
                .i_ra    (ra[p*ADDR_W +: ADDR_W]),
                .o_rd    (rd[p*DATA_W +: DATA_W])
            );
        end
    endgenerate

    assign ready   = r_ready;
    assign wr_drop = r_wr_drop;

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp against a behavioural array model.
module tb_regfile_mp;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              we;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd;
    logic [NR*AW-1:0]  ra;
    logic [NR*DW-1:0]  rd;
    logic              ready;
    logic              wr_drop;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem_m [DEPTH];
    int            clear_left;
    logic          drop_m;

    always #5 clk = ~clk;

    regfile_mp #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .NRD      (NR),
        .ZERO_REG (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .wa      (wa),
        .wd      (wd),
        .ra      (ra),
        .rd      (rd),
        .ready   (ready),
        .wr_drop (wr_drop)
    );

    function automatic logic [DW-1:0] exp_rd(int p);
        logic [AW-1:0] idx;
        idx = ra[p*AW +: AW];
        if (clear_left > 0) return '0;
        if (idx == '0) return '0;
        if (BYP && we && (wa == idx)) return wd;
        return mem_m[idx];
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int p = 0; p < NR; p++) begin
            chk($sformatf("%s rd%0d", tag, p), rd[p*DW +: DW], exp_rd(p));
        end
        chk({tag, " ready"}, {31'b0, ready}, {31'b0, (clear_left == 0)});
        chk({tag, " wr_drop"}, {31'b0, wr_drop}, {31'b0, drop_m});
    endtask

    // Advance one clock edge, updating the model from the inputs present before it
    task automatic tick();
        if (clear_left > 0) begin
            mem_m[DEPTH - clear_left] = '0;
            clear_left--;
            drop_m = we;
        end else begin
            drop_m = we && (wa == '0);
            if (we && (wa != '0)) mem_m[wa] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input int a0, input int a1);
        ra = {AW'(a1), AW'(a0)};
    endtask

    task automatic rand_ra();
        ra = NR*AW'($urandom);
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        wa    = '0;
        wd    = '0;
        ra    = '0;
        clear_left = DEPTH;
        drop_m     = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;

        #1;
        check_all("in_reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // CLEAR walk with a write attempt in cycle 10
        for (int i = 0; i < DEPTH; i++) begin
            rand_ra();
            if (i == 10) begin
                we = 1'b1; wa = 5'd9; wd = 32'h55;
            end else begin
                we = 1'b0;
            end
            #1;
            check_all($sformatf("clear%0d", i));
            tick();
            if (i == 10) chk("clear_write_drop", {31'b0, wr_drop}, 32'd1);
        end
        we = 1'b0;
        chk("ready_after_clear", {31'b0, ready}, 32'd1);
        for (int i = 0; i < DEPTH; i += 2) begin
            set_ra(i, i + 1);
            #1;
            check_all($sformatf("zeroed%0d", i));
        end
        set_ra(9, 9);
        #1;
        chk("idx9_zero", rd[DW-1:0], 32'h0);

        // Basic write, then dual read of the same index
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        tick();
        we = 1'b0; set_ra(5, 5);
        #1;
        check_all("wr5");
        chk("wr5_p0", rd[0 +: DW], 32'hDEADBEEF);
        chk("wr5_p1", rd[DW +: DW], 32'hDEADBEEF);

        // Write to the hardwired zero register
        we = 1'b1; wa = 5'd0; wd = 32'h12345678; set_ra(0, 0);
        tick();
        we = 1'b0;
        #1;
        check_all("wr0");
        chk("wr0_drop", {31'b0, wr_drop}, 32'd1);
        chk("wr0_rd", rd[0 +: DW], 32'h0);
        tick();
        chk("wr0_drop_clear", {31'b0, wr_drop}, 32'd0);

        // Same-cycle write/read of one index
        we = 1'b1; wa = 5'd7; wd = 32'h1;
        tick();
        we = 1'b1; wa = 5'd7; wd = 32'hA5A5A5A5; set_ra(7, 3);
        #1;
        check_all("byp");
        chk("byp_same_cycle", rd[0 +: DW], BYP ? 32'hA5A5A5A5 : 32'h1);
        tick();
        we = 1'b0;
        #1;
        chk("byp_next_cycle", rd[0 +: DW], 32'hA5A5A5A5);

        // Randomised traffic in RUN
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom);
            wa = AW'($urandom);
            wd = $urandom;
            rand_ra();
            if (($urandom % 4) == 0) ra[AW-1:0] = wa;
            #1;
            check_all($sformatf("rnd%0d", i));
            tick();
        end
        we = 1'b0;

        // Reset mid-cycle in RUN after writing index 3
        we = 1'b1; wa = 5'd3; wd = 32'hFF;
        tick();
        we = 1'b0;
        #3;
        reset = 1'b1;
        clear_left = DEPTH;
        drop_m = 1'b0;
        #1;
        chk("reset_ready_drop", {31'b0, ready}, 32'd0);
        check_all("reset_run");
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset again part-way through CLEAR
        for (int i = 0; i < 5; i++) tick();
        #3;
        reset = 1'b1;
        clear_left = DEPTH;
        drop_m = 1'b0;
        #1;
        check_all("reset_clear");
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rand_ra();
            #1;
            check_all($sformatf("reclear%0d", i));
            tick();
        end
        set_ra(3, 3);
        #1;
        check_all("idx3_after_reset");
        chk("idx3_zero", rd[0 +: DW], 32'h0);
        chk("ready_after_reclear", {31'b0, ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_regfile_mp

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, meaning register index width; depth is 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 32, meaning register word width.
REQ-003 SHALL have parameter NRD, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning that index 0 is hardwired to zero when 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port we, input, 1 bit: write enable.
REQ-008 SHALL have port wa, input, ADDR_W bits: write index.
REQ-009 SHALL have port wd, input, DATA_W bits: write data.
REQ-010 SHALL have port ra, input, NRD*ADDR_W bits: read indices; port p uses bits [p*ADDR_W +: ADDR_W].
REQ-011 SHALL have port rd, output, NRD*DATA_W bits: read data; port p drives bits [p*DATA_W +: DATA_W].
REQ-012 SHALL have port ready, output, 1 bit: array initialised and accepting writes.
REQ-013 SHALL have port wr_drop, output, 1 bit: registered pulse flagging a write that was discarded.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR and RUN.
REQ-015 In CLEAR: SHALL write zero to entry clr_idx each cycle, then increment clr_idx; clr_idx is ADDR_W bits wide.
REQ-016 When clr_idx equals 2**ADDR_W-1 in CLEAR: SHALL write that entry and enter RUN on the same edge; CLEAR lasts exactly 2**ADDR_W cycles.
REQ-017 ready SHALL be 0 in CLEAR and 1 in RUN. ready is registered and rises on the edge that enters RUN.
REQ-018 In RUN with we=1: SHALL store wd into entry wa on the rising edge, except under REQ-019.
REQ-019 With ZERO_REG=1 and wa=0: the write SHALL be discarded and wr_drop SHALL pulse 1 on the following cycle.
REQ-020 A write with we=1 during CLEAR SHALL be discarded, with wr_drop pulsing 1 on the following cycle; otherwise wr_drop SHALL be 0.
REQ-021 Reads SHALL be combinational: rd[p] = entry ra[p]. All NRD ports are independent; identical indices on several ports are legal.
REQ-022 With ZERO_REG=1, any read of index 0 SHALL return 0 regardless of array contents.
REQ-023 Every read port SHALL return 0 while in CLEAR.
REQ-024 A write and a read to the same index in one cycle SHALL behave per REQ-030/REQ-031.

Reset
REQ-025 Asserting reset SHALL immediately force state=CLEAR, clr_idx=0, ready=0 and wr_drop=0, independent of clk.
REQ-026 Array contents SHALL NOT be asynchronously reset; zeroing occurs only through the CLEAR sequence.
REQ-027 Reset asserted mid-CLEAR or mid-RUN SHALL restart CLEAR from index 0 after deassertion.
REQ-028 After reset deassertion, the first CLEAR write SHALL occur on the first rising clk edge.

Configuration
REQ-029 Feature macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 With REGFILE_BYPASS_EN defined, in RUN: when we=1, wa=ra[p] and the write is not discarded, rd[p] SHALL equal wd combinationally in that same cycle.
REQ-031 Without REGFILE_BYPASS_EN, rd[p] SHALL return the pre-write value in that cycle and the new value from the next cycle.

Structure
REQ-032 A shared package regfile_pkg SHALL hold the FSM state encoding (CLEAR=1'b0, RUN=1'b1) and the default constants for ADDR_W, DATA_W and NRD.
REQ-033 One sub-module, regfile_rdport, SHALL implement a single read port (index select, zero-register mask, CLEAR mask, optional bypass). It SHALL be instantiated NRD times via generate.
REQ-034 The storage array and FSM SHALL reside in regfile_mp.

Verification
REQ-035 Reset pulse, then idle: ready=0 for exactly 32 cycles (ADDR_W=5) and 1 after; every index reads 0.
REQ-036 In RUN, write wa=5, wd=0xDEADBEEF; next cycle ra={5,5}: both ports read 0xDEADBEEF.
REQ-037 Write wa=0, wd=0x12345678 with ZERO_REG=1: rd of index 0 stays 0, and wr_drop=1 for one cycle.
REQ-038 Same-cycle we=1, wa=7, wd=0xA5A5A5A5 with ra[0]=7 (previous value 0x1): rd[0]=0xA5A5A5A5 with REGFILE_BYPASS_EN, 0x1 without; both builds read 0xA5A5A5A5 next cycle.
REQ-039 Write 0xFF to index 3 in RUN, assert reset 1 ns mid-cycle: ready drops immediately; after 32 cycles index 3 reads 0.
REQ-040 we=1, wa=9, wd=0x55 during CLEAR cycle 10: wr_drop=1 next cycle; index 9 reads 0 after ready.
